nf_coeff_loader: RTL and testbench

Coefficient writer for the CRPA null-steering filter. It accepts a serial stream of signed FIR weights from the host/estimator side into a shadow bank. On command it transfers the full bank atomically onto the `coeffs_concat` bus consumed by NullFormer, so the filter never sees a partially updated weight set. It sits between the register/DMA front end and the NullFormer `coeffs_concat` input.

---
 rtl/nf_coeff_loader.sv | 143 ++++++++++++++
 tb/tb_nf_coeff_loader.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nf_coeff_loader.sv
// nf_coeff_loader
//
// Coefficient writer for the CRPA null-steering filter. Signed FIR weights
// arrive one per cycle into a shadow bank; a commit then transfers the whole
// bank onto coeffs_concat in a single clock edge, so NullFormer never sees a
// partially updated weight set.
//
// Ports:
//   clk           in   system clock, rising edge
//   reset         in   synchronous, active-high reset
//   wr_data       in   signed coefficient word
//   wr_valid      in   wr_data is presented
//   wr_last       in   final word of a set (qualified by wr_valid)
//   wr_ready      out  loader can accept a word
//   commit        in   single-cycle request: shadow -> active (only in FULL)
//   abort         in   single-cycle request: discard the load in progress
//   coeffs_concat out  active bank, word i at [(i+1)*COEFF_WIDTH-1 : i*COEFF_WIDTH]
//   coeffs_valid  out  at least one commit since reset
//   load_err      out  sticky framing error, cleared by first word of a new load
//   wr_count      out  words accepted in the current load
module nf_coeff_loader #(
    parameter  int NCH         = 4,
    parameter  int NT          = 8,
    parameter  int COEFF_WIDTH = 16,
    localparam int NCOEF       = (NCH - 1) * NT,
    localparam int PW          = $clog2(NCOEF)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [COEFF_WIDTH-1:0]       wr_data,
    input  logic                         wr_valid,
    input  logic                         wr_last,
    output logic                         wr_ready,
    input  logic                         commit,
    input  logic                         abort,
    output logic [NCOEF*COEFF_WIDTH-1:0] coeffs_concat,
    output logic                         coeffs_valid,
    output logic                         load_err,
    output logic [PW:0]                  wr_count
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_FULL = 2'd2;

    localparam logic [PW:0] LAST_IDX = (PW + 1)'(NCOEF - 1);

    logic [1:0]                   r_state;
    logic [PW:0]                  r_wr_count;
    logic                         r_wr_ready;
    logic                         r_load_err;
    logic                         r_coeffs_valid;
    logic [NCOEF*COEFF_WIDTH-1:0] r_active;
    logic [COEFF_WIDTH-1:0]       r_shadow [NCOEF];

    logic                         w_accept;
    logic                         w_at_last_idx;
    logic                         w_frame_err;
    logic [PW-1:0]                w_idx;
    logic [NCOEF*COEFF_WIDTH-1:0] w_shadow_flat;

    // An abort in the same cycle drops the word.
    assign w_accept      = wr_valid & r_wr_ready & ~abort;
    assign w_at_last_idx = (r_wr_count == LAST_IDX);
    // wr_last early, or missing on the final word, is a framing error.
    assign w_frame_err   = w_accept & (wr_last ^ w_at_last_idx);
    assign w_idx         = r_wr_count[PW-1:0];

    always_comb begin
        w_shadow_flat = '0;
        for (int unsigned i = 0; i < NCOEF; i++) begin
            w_shadow_flat[i*COEFF_WIDTH +: COEFF_WIDTH] = r_shadow[i];
        end
    end

    // Shadow bank is deliberately not reset; it is only read after a full load.
    always_ff @(posedge clk) begin
        if (!reset && w_accept) begin
            r_shadow[w_idx] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_wr_count     <= '0;
            r_wr_ready     <= 1'b1;
            r_load_err     <= 1'b0;
            r_coeffs_valid <= 1'b0;
            r_active       <= '0;
        end else if (abort) begin
            if (r_state != S_IDLE) begin
                r_state    <= S_IDLE;
                r_wr_count <= '0;
                r_wr_ready <= 1'b1;
            end
        end else begin
            case (r_state)
                S_IDLE, S_LOAD: begin
                    if (w_accept) begin
                        if (w_frame_err) begin
                            r_load_err <= 1'b1;
                            r_state    <= S_IDLE;
                            r_wr_count <= '0;
                        end else begin
                            if (r_state == S_IDLE) begin
                                r_load_err <= 1'b0;
                            end
                            r_wr_count <= r_wr_count + 1'b1;
                            if (w_at_last_idx) begin
                                r_state    <= S_FULL;
                                r_wr_ready <= 1'b0;
                            end else begin
                                r_state <= S_LOAD;
                            end
                        end
                    end
                end
                S_FULL: begin
                    if (commit) begin
                        r_active       <= w_shadow_flat;
                        r_coeffs_valid <= 1'b1;
                        r_state        <= S_IDLE;
                        r_wr_count     <= '0;
                        r_wr_ready     <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_wr_count <= '0;
                    r_wr_ready <= 1'b1;
                end
            endcase
        end
    end

    assign wr_ready      = r_wr_ready;
    assign coeffs_concat = r_active;
    assign coeffs_valid  = r_coeffs_valid;
    assign load_err      = r_load_err;
    assign wr_count      = r_wr_count;

endmodule

// File: tb/tb_nf_coeff_loader.sv
// Directed self-checking bench for nf_coeff_loader (NCH=4, NT=8, 16-bit).
module tb_nf_coeff_loader;

    localparam int NCH   = 4;
    localparam int NT    = 8;
    localparam int CW    = 16;
    localparam int NCOEF = 24;
    localparam int PW    = 5;
    localparam int BW    = NCOEF * CW;

    logic          clk;
    logic          reset;
    logic [CW-1:0] wr_data;
    logic          wr_valid;
    logic          wr_last;
    logic          wr_ready;
    logic          commit;
    logic          abort;
    logic [BW-1:0] coeffs_concat;
    logic          coeffs_valid;
    logic          load_err;
    logic [PW:0]   wr_count;

    int errors = 0;
    int checks = 0;

    logic [BW-1:0] bank_pos;
    logic [BW-1:0] bank_neg;

    nf_coeff_loader #(.NCH(NCH), .NT(NT), .COEFF_WIDTH(CW)) dut (
        .clk           (clk),
        .reset         (reset),
        .wr_data       (wr_data),
        .wr_valid      (wr_valid),
        .wr_last       (wr_last),
        .wr_ready      (wr_ready),
        .commit        (commit),
        .abort         (abort),
        .coeffs_concat (coeffs_concat),
        .coeffs_valid  (coeffs_valid),
        .load_err      (load_err),
        .wr_count      (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Word i of the bank = sign*(i+1)
    function automatic logic [BW-1:0] make_bank(input int sign);
        logic [BW-1:0] v;
        v = '0;
        for (int i = 0; i < NCOEF; i++) begin
            v[i*CW +: CW] = CW'(sign * (i + 1));
        end
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        wr_valid = 1'b0;
        wr_last  = 1'b0;
        wr_data  = '0;
        commit   = 1'b0;
        abort    = 1'b0;
    endtask

    // Stream n words sign*(i+1), wr_last on index last_at (-1: never).
    task automatic load_words(input int sign, input int n, input int last_at);
        for (int i = 0; i < n; i++) begin
            wr_valid = 1'b1;
            wr_data  = CW'(sign * (i + 1));
            wr_last  = (i == last_at);
            tick();
        end
        wr_valid = 1'b0;
        wr_last  = 1'b0;
    endtask

    task automatic pulse_commit();
        commit = 1'b1;
        tick();
        commit = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        checks++; if (coeffs_concat !== '0) begin errors++; $display("FAIL reset_concat: got %0h expected 0", coeffs_concat); end
        checks++; if (coeffs_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", coeffs_valid); end
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b expected 1", wr_ready); end
        checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b expected 0", load_err); end
        checks++; if (wr_count !== 6'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", wr_count); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < NCOEF; i++) begin
            wr_valid = 1'b1;
            wr_data  = CW'(i + 1);
            wr_last  = (i == NCOEF - 1);
            tick();
            if (i == 0) begin
                checks++; if (wr_count !== 6'd1) begin errors++; $display("FAIL b2b_count_first: got %0d expected 1", wr_count); end
            end
            if (i == NCOEF - 2) begin
                checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_w23: got %0b expected 1", wr_ready); end
                checks++; if (wr_count !== 6'd23) begin errors++; $display("FAIL b2b_count_w23: got %0d expected 23", wr_count); end
            end
        end
        // Keep wr_valid high in FULL: it must be ignored.
        wr_last = 1'b0;
        wr_data = 16'hDEAD;
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_full: got %0b expected 0", wr_ready); end
        checks++; if (wr_count !== 6'd24) begin errors++; $display("FAIL b2b_count_full: got %0d expected 24", wr_count); end
        tick();
        wr_valid = 1'b0;
        tick();
        checks++; if (wr_count !== 6'd24) begin errors++; $display("FAIL b2b_full_ignore: got %0d expected 24", wr_count); end
        checks++; if (coeffs_concat !== '0) begin errors++; $display("FAIL b2b_precommit: got %0h expected 0", coeffs_concat); end
        tick();
        pulse_commit();
        checks++; if (coeffs_concat !== bank_pos) begin errors++; $display("FAIL b2b_concat: got %0h expected %0h", coeffs_concat, bank_pos); end
        checks++; if (coeffs_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %0b expected 1", coeffs_valid); end
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_after: got %0b expected 1", wr_ready); end
        checks++; if (wr_count !== 6'd0) begin errors++; $display("FAIL b2b_count_after: got %0d expected 0", wr_count); end
    endtask

    task automatic test_gapped_update();
        int hold_bad;
        hold_bad = 0;
        for (int i = 0; i < NCOEF; i++) begin
            int gap;
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                wr_valid = 1'b0;
                tick();
                if (coeffs_concat !== bank_pos) hold_bad++;
            end
            wr_valid = 1'b1;
            wr_data  = CW'(-(i + 1));
            wr_last  = (i == NCOEF - 1);
            tick();
            if (coeffs_concat !== bank_pos) hold_bad++;
        end
        wr_valid = 1'b0;
        wr_last  = 1'b0;
        checks++; if (hold_bad !== 0) begin errors++; $display("FAIL gap_active_hold: got %0d bad cycles expected 0", hold_bad); end
        tick();
        checks++; if (coeffs_concat !== bank_pos) begin errors++; $display("FAIL gap_precommit: got %0h expected %0h", coeffs_concat, bank_pos); end
        pulse_commit();
        checks++; if (coeffs_concat !== bank_neg) begin errors++; $display("FAIL gap_flip: got %0h expected %0h", coeffs_concat, bank_neg); end
    endtask

    task automatic test_early_last();
        load_words(1, 10, 9);
        checks++; if (load_err !== 1'b1) begin errors++; $display("FAIL early_err: got %0b expected 1", load_err); end
        checks++; if (wr_count !== 6'd0) begin errors++; $display("FAIL early_count: got %0d expected 0", wr_count); end
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL early_ready: got %0b expected 1", wr_ready); end
        pulse_commit();
        checks++; if (coeffs_concat !== bank_neg) begin errors++; $display("FAIL early_active: got %0h expected %0h", coeffs_concat, bank_neg); end
        checks++; if (load_err !== 1'b1) begin errors++; $display("FAIL early_sticky: got %0b expected 1", load_err); end
        wr_valid = 1'b1;
        wr_data  = 16'h0055;
        tick();
        wr_valid = 1'b0;
        checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL early_clear: got %0b expected 0", load_err); end
        checks++; if (wr_count !== 6'd1) begin errors++; $display("FAIL early_newload: got %0d expected 1", wr_count); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++; if (wr_count !== 6'd0) begin errors++; $display("FAIL early_abort: got %0d expected 0", wr_count); end
    endtask

    task automatic test_missing_last();
        load_words(1, NCOEF, -1);
        checks++; if (load_err !== 1'b1) begin errors++; $display("FAIL nolast_err: got %0b expected 1", load_err); end
        checks++; if (wr_count !== 6'd0) begin errors++; $display("FAIL nolast_count: got %0d expected 0", wr_count); end
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL nolast_ready: got %0b expected 1", wr_ready); end
        pulse_commit();
        checks++; if (coeffs_concat !== bank_neg) begin errors++; $display("FAIL nolast_active: got %0h expected %0h", coeffs_concat, bank_neg); end
    endtask

    task automatic test_commit_abort();
        // Word together with abort is dropped.
        load_words(1, 5, -1);
        wr_valid = 1'b1;
        wr_data  = 16'h7777;
        abort    = 1'b1;
        tick();
        clear_inputs();
        checks++; if (wr_count !== 6'd0) begin errors++; $display("FAIL abortword_count: got %0d expected 0", wr_count); end
        load_words(1, NCOEF, NCOEF - 1);
        checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL ca_err_cleared: got %0b expected 0", load_err); end
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL ca_full: got %0b expected 0", wr_ready); end
        commit = 1'b1;
        abort  = 1'b1;
        tick();
        clear_inputs();
        checks++; if (coeffs_concat !== bank_neg) begin errors++; $display("FAIL ca_active: got %0h expected %0h", coeffs_concat, bank_neg); end
        checks++; if (wr_count !== 6'd0) begin errors++; $display("FAIL ca_count: got %0d expected 0", wr_count); end
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL ca_ready: got %0b expected 1", wr_ready); end
        pulse_commit();
        checks++; if (coeffs_concat !== bank_neg) begin errors++; $display("FAIL ca_idle_commit: got %0h expected %0h", coeffs_concat, bank_neg); end
    endtask

    task automatic test_reset_midload();
        load_words(1, 12, -1);
        checks++; if (wr_count !== 6'd12) begin errors++; $display("FAIL mid_count: got %0d expected 12", wr_count); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (coeffs_concat !== '0) begin errors++; $display("FAIL mid_concat: got %0h expected 0", coeffs_concat); end
        checks++; if (coeffs_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %0b expected 0", coeffs_valid); end
        checks++; if (wr_count !== 6'd0) begin errors++; $display("FAIL mid_count_rst: got %0d expected 0", wr_count); end
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL mid_ready: got %0b expected 1", wr_ready); end
        checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL mid_err: got %0b expected 0", load_err); end
    endtask

    initial begin
        bank_pos = make_bank(1);
        bank_neg = make_bank(-1);
        reset    = 1'b1;
        clear_inputs();
        test_reset();
        test_back_to_back();
        test_gapped_update();
        test_early_last();
        test_missing_last();
        test_commit_abort();
        test_reset_midload();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
